// File: rtl/rlc_game_system_pulse_pio.sv
// rtl/rlc_game_system_pulse_pio.sv - Avalon-MM output PIO with atomic set/clear and timed pulses
//
// Purpose: DATA_WIDTH-bit output register for game-logic enables/strobes. Bits can be
// loaded, set, cleared, or pulsed high for a programmable number of clk cycles.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   address      word address (0 DATA, 2 STATUS, 3 PMASK, 4 OUTSET, 5 OUTCLEAR, 6 PULSE, 7 PLEN)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data (bits above the target register width ignored)
//   readdata     combinational read data, zero-extended
//   out_port     data register value
//   pulse_active high while a pulse countdown is running

module rlc_game_system_pulse_pio #(
    parameter int          DATA_WIDTH        = 8,
    parameter int unsigned RESET_VALUE       = 0,
    parameter int          COUNT_WIDTH       = 16,
    parameter int unsigned DEFAULT_PULSE_LEN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_active
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_PMASK    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_PULSE    = 3'd6;
    localparam logic [2:0] ADDR_PLEN     = 3'd7;

    logic [DATA_WIDTH-1:0]  data_q,  data_d;
    logic [DATA_WIDTH-1:0]  pmask_q, pmask_d;
    logic [COUNT_WIDTH-1:0] plen_q,  plen_d;
    logic [COUNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic                   active_q;

    logic                   wr;
    logic                   load_or_pulse;
    logic [DATA_WIDTH-1:0]  wd;
    logic [COUNT_WIDTH-1:0] wd_len;
    logic [COUNT_WIDTH-1:0] pulse_len;
    logic                   unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign wd_len    = writedata[COUNT_WIDTH-1:0];
    assign unused_wd = ^writedata;

    // A zero pulse length still yields a one-cycle pulse.
    assign pulse_len = (plen_q == '0) ? COUNT_WIDTH'(1) : plen_q;

    // DATA and PULSE writes own the counter this cycle; the countdown yields to them.
    assign load_or_pulse = wr && ((address == ADDR_DATA) || (address == ADDR_PULSE));

    always_comb begin
        data_d  = data_q;
        pmask_d = pmask_q;
        plen_d  = plen_q;
        cnt_d   = cnt_q;

        if (wr) begin
            case (address)
                ADDR_DATA: begin
                    data_d  = wd;
                    pmask_d = '0;
                    cnt_d   = '0;
                end
                ADDR_OUTSET:   data_d = data_q | wd;
                ADDR_OUTCLEAR: data_d = data_q & ~wd;
                ADDR_PULSE: begin
                    data_d  = data_q | wd;
                    pmask_d = pmask_q | wd;
                    cnt_d   = pulse_len;
                end
                ADDR_PLEN:     plen_d = wd_len;
                default: ;
            endcase
        end

        // Expiry is applied on top of any set/clear result from this same edge.
        if (!load_or_pulse && (cnt_q != '0)) begin
            if (cnt_q == COUNT_WIDTH'(1)) begin
                data_d  = data_d & ~pmask_q;
                pmask_d = '0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= DATA_WIDTH'(RESET_VALUE);
            pmask_q  <= '0;
            plen_q   <= COUNT_WIDTH'(DEFAULT_PULSE_LEN);
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            pmask_q  <= pmask_d;
            plen_q   <= plen_d;
            cnt_q    <= cnt_d;
            // Tracks cnt != 0 from a flop so the output never glitches.
            active_q <= (cnt_d != '0);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_STATUS: readdata = {31'd0, active_q};
            ADDR_PMASK:  readdata = 32'(pmask_q);
            ADDR_PLEN:   readdata = 32'(plen_q);
            default:     readdata = '0;
        endcase
    end

    assign out_port     = data_q;
    assign pulse_active = active_q;

endmodule

// File: tb/tb_rlc_game_system_pulse_pio.sv
// tb/tb_rlc_game_system_pulse_pio.sv - self-checking bench for rlc_game_system_pulse_pio

module tb_rlc_game_system_pulse_pio;

    localparam int          DW  = 8;
    localparam int          CW  = 16;
    localparam int unsigned RV  = 32'hA5;
    localparam int unsigned DPL = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [DW-1:0] out_port;
    logic        pulse_active;

    always #5 clk = ~clk;

    rlc_game_system_pulse_pio #(
        .DATA_WIDTH(DW),
        .RESET_VALUE(RV),
        .COUNT_WIDTH(CW),
        .DEFAULT_PULSE_LEN(DPL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port),
        .pulse_active(pulse_active)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: a pulse is described by the absolute edge number on which it expires.
    logic [7:0]  m_data;
    logic [7:0]  m_pmask;
    logic [15:0] m_plen;
    int          m_edge = 0;
    int          m_deadline = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic m_pa();
        return m_deadline > m_edge;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd2:    return {31'd0, m_pa()};
            3'd3:    return {24'd0, m_pmask};
            3'd7:    return {16'd0, m_plen};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic [2:0] a, input logic cs, input logic wn,
                              input logic [31:0] wd, input logic rst);
        bit owns;
        int len;
        m_edge++;
        owns = 0;
        if (rst) begin
            m_data     = RV[7:0];
            m_pmask    = 8'd0;
            m_plen     = DPL[15:0];
            m_deadline = 0;
        end else begin
            if (cs && !wn) begin
                case (a)
                    3'd0: begin
                        m_data = wd[7:0]; m_pmask = 8'd0; m_deadline = 0; owns = 1;
                    end
                    3'd4: m_data = m_data | wd[7:0];
                    3'd5: m_data = m_data & ~wd[7:0];
                    3'd6: begin
                        len = (m_plen == 16'd0) ? 1 : int'(m_plen);
                        m_data = m_data | wd[7:0];
                        m_pmask = m_pmask | wd[7:0];
                        m_deadline = m_edge + len;
                        owns = 1;
                    end
                    3'd7: m_plen = wd[15:0];
                    default: ;
                endcase
            end
            if (!owns && m_deadline != 0 && m_deadline == m_edge) begin
                m_data = m_data & ~m_pmask;
                m_pmask = 8'd0;
                m_deadline = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_port", {24'd0, out_port}, {24'd0, m_data});
            chk("pulse_active", {31'd0, pulse_active}, {31'd0, m_pa()});
            chk("readdata", readdata, m_rd(address));
        end
    end

    task automatic cyc(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic rst);
        address = a; chipselect = cs; write_n = wn; writedata = wd; reset = rst;
        @(posedge clk);
        model_step(a, cs, wn, wd, rst);
        #1;
        chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(a, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic idle();
        cyc(address, 1'b0, 1'b1, $urandom, 1'b0);
    endtask

    task automatic peek(input logic [2:0] a);
        address = a;
        #1;
    endtask

    initial begin
        int n, na, b0, b2, l0, l2;
        logic [2:0]  ra;
        logic        rcs, rwn, rrs;
        logic [31:0] rwd;

        // Reset state
        cyc(3'd0, 1'b1, 1'b0, 32'hFF, 1'b1);
        chk_en = 1'b1;
        cyc(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
        chk("rst_out", {24'd0, out_port}, 32'hA5);
        chk("rst_pa", {31'd0, pulse_active}, 32'd0);
        peek(3'd7); chk("rst_plen", readdata, 32'd1);
        peek(3'd2); chk("rst_status", readdata, 32'd0);
        peek(3'd3); chk("rst_pmask", readdata, 32'd0);

        // Set / clear
        wr(3'd0, 32'h0F);  chk("set_data", {24'd0, out_port}, 32'h0F);
        wr(3'd4, 32'h30);  chk("outset", {24'd0, out_port}, 32'h3F);
        wr(3'd5, 32'h03);  chk("outclear", {24'd0, out_port}, 32'h3C);
        peek(3'd0); chk("rd_data", readdata, 32'h3C);
        peek(3'd4); chk("rd_outset", readdata, 32'h0);

        // Pulse timing, PLEN=5
        wr(3'd0, 32'h0);
        wr(3'd7, 32'd5);
        wr(3'd6, 32'h81);
        n = 0; na = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_port == 8'h81) n++;
            if (pulse_active) na++;
            idle();
        end
        chk("pulse_len5", n, 5);
        chk("pulse_pa5", na, 5);
        chk("pulse_after", {24'd0, out_port}, 32'h0);
        peek(3'd3); chk("pmask_after", readdata, 32'h0);

        // PLEN=0 gives a one-cycle pulse
        wr(3'd7, 32'd0);
        wr(3'd6, 32'h02);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_port[1]) n++;
            idle();
        end
        chk("pulse_len0", n, 1);

        // Retrigger
        wr(3'd7, 32'd4);
        b0 = 0; b2 = 0; l0 = -1; l2 = -2;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) wr(3'd6, 32'h01);
            else if (i == 2) wr(3'd6, 32'h04);
            else idle();
            if (out_port[0]) begin b0++; l0 = i; end
            if (out_port[2]) begin b2++; l2 = i; end
        end
        chk("retrig_b0", b0, 6);
        chk("retrig_b2", b2, 4);
        chk("retrig_same_edge", l0, l2);

        // Cancel by DATA write
        wr(3'd7, 32'd10);
        wr(3'd6, 32'h10);
        idle(); idle();
        wr(3'd0, 32'h10);
        chk("cancel_out", {24'd0, out_port}, 32'h10);
        chk("cancel_pa", {31'd0, pulse_active}, 32'd0);
        peek(3'd3); chk("cancel_pmask", readdata, 32'h0);
        for (int i = 0; i < 12; i++) idle();
        chk("cancel_hold", {24'd0, out_port}, 32'h10);

        // Reset aborts a pulse
        wr(3'd0, 32'h0);
        wr(3'd6, 32'h10);
        idle(); idle();
        cyc(3'd0, 1'b0, 1'b1, 32'h0, 1'b1);
        chk("abort_out", {24'd0, out_port}, 32'hA5);
        chk("abort_pa", {31'd0, pulse_active}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rcs = ($urandom_range(0, 3) != 0);
            rwn = ($urandom_range(0, 1) != 0);
            rwd = $urandom;
            if (ra == 3'd7) rwd = {29'd0, 3'($urandom_range(0, 7))};
            rrs = ($urandom_range(0, 299) == 0);
            cyc(ra, rcs, rwn, rwd, rrs);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
